// File: rtl/contador_programa.sv
// contador_programa: program counter with jump, relative branch, call/return stack and halt
module contador_programa #(
  parameter int PROFUNDIDADE = 4,
  parameter logic [7:0] ENDERECO_INICIAL = 8'd0,
  localparam int NW = $clog2(PROFUNDIDADE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          habilita,
  input  logic          salto,
  input  logic          desvio,
  input  logic          chamada,
  input  logic          retorno,
  input  logic [7:0]    alvo,
  input  logic          parar,
  input  logic          retomar,
  output logic [7:0]    endereco,
  output logic          parado,
  output logic          erro,
  output logic [NW-1:0] nivel
);
  typedef enum logic [1:0] {EXECUTANDO, PARADO, ERRO} estado_t;
  localparam int N = 1 << NW;
  localparam logic [NW-1:0] CHEIO = NW'(PROFUNDIDADE);
  estado_t estado_q, estado_d;
  logic [7:0] pc_q, pc_d;
  logic [NW-1:0] nivel_q, nivel_d;
  logic [7:0] pilha_q [N];
  logic empilha;
  always_comb begin
    estado_d = estado_q;
    pc_d = pc_q;
    nivel_d = nivel_q;
    empilha = 1'b0;
    if (habilita && estado_q == EXECUTANDO) begin
      if (parar) estado_d = PARADO;
      else if (salto) pc_d = alvo;
      else if (desvio) pc_d = pc_q + alvo;
      else if (chamada) begin
        if (nivel_q < CHEIO) begin
          empilha = 1'b1;
          nivel_d = nivel_q + NW'(1);
          pc_d = alvo;
        end else estado_d = ERRO;
      end else if (retorno) begin
        if (nivel_q != '0) begin
          pc_d = pilha_q[nivel_q - NW'(1)];
          nivel_d = nivel_q - NW'(1);
        end else estado_d = ERRO;
      end else pc_d = pc_q + 8'd1;
    end else if (habilita && estado_q == PARADO && retomar) estado_d = EXECUTANDO;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= EXECUTANDO;
      pc_q <= ENDERECO_INICIAL;
      nivel_q <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q <= pc_d;
      nivel_q <= nivel_d;
    end
  end
  // stack contents need no reset: nivel alone says which entries are valid
  always_ff @(posedge clock) begin
    if (!reset && empilha) pilha_q[nivel_q] <= pc_q + 8'd1;
  end
  assign endereco = pc_q;
  assign nivel = nivel_q;
  assign parado = estado_q == PARADO;
  assign erro = estado_q == ERRO;
endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa: directed self-checking bench for contador_programa
module tb_contador_programa;
  logic clock = 1'b0;
  logic reset, habilita, salto, desvio, chamada, retorno, parar, retomar;
  logic [7:0] alvo, endereco;
  logic parado, erro;
  logic [2:0] nivel;
  int checks = 0;
  int errors = 0;

  contador_programa #(.PROFUNDIDADE(4), .ENDERECO_INICIAL(8'd0)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .salto(salto), .desvio(desvio),
    .chamada(chamada), .retorno(retorno), .alvo(alvo), .parar(parar), .retomar(retomar),
    .endereco(endereco), .parado(parado), .erro(erro), .nivel(nivel)
  );

  always #5 clock = ~clock;

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic limpa();
    salto = 0; desvio = 0; chamada = 0; retorno = 0; parar = 0; retomar = 0; alvo = 8'h00;
  endtask

  task automatic pc(input string tag, input logic [7:0] exp);
    checar(tag, 32'(endereco), 32'(exp));
  endtask

  initial begin
    reset = 1; habilita = 0; limpa();
    passo(); passo();
    pc("reset_pc", 8'h00);
    checar("reset_nivel", 32'(nivel), 0);
    checar("reset_parado", 32'(parado), 0);
    checar("reset_erro", 32'(erro), 0);
    reset = 0; habilita = 1;
    for (int i = 1; i <= 5; i++) begin
      passo();
      pc($sformatf("incr_%0d", i), 8'(i));
    end
    salto = 1; alvo = 8'hFE; passo(); pc("salto_fe", 8'hFE);
    limpa(); passo(); pc("incr_ff", 8'hFF);
    passo(); pc("wrap_00", 8'h00);
    habilita = 0; salto = 1; chamada = 1; parar = 1; alvo = 8'h55;
    for (int i = 0; i < 3; i++) begin
      passo();
      pc("freeze_pc", 8'h00);
    end
    checar("freeze_nivel", 32'(nivel), 0);
    checar("freeze_parado", 32'(parado), 0);
    limpa(); habilita = 1;
    salto = 1; alvo = 8'h10; passo(); pc("salto_10", 8'h10);
    limpa(); desvio = 1; alvo = 8'hFC; passo(); pc("desvio_neg", 8'h0C);
    alvo = 8'h7F; passo(); pc("desvio_7f", 8'h8B);
    alvo = 8'h00; passo(); pc("desvio_zero", 8'h8B);
    alvo = 8'h80; passo(); pc("desvio_m128", 8'h0B);
    limpa(); salto = 1; alvo = 8'h20; passo(); pc("salto_20", 8'h20);
    limpa(); chamada = 1; alvo = 8'h40; passo(); pc("call_40", 8'h40);
    checar("call1_nivel", 32'(nivel), 1);
    limpa(); passo(); pc("incr_41", 8'h41);
    chamada = 1; alvo = 8'h60; passo(); pc("call_60", 8'h60);
    checar("call2_nivel", 32'(nivel), 2);
    limpa(); retorno = 1; passo(); pc("ret_42", 8'h42);
    checar("ret1_nivel", 32'(nivel), 1);
    passo(); pc("ret_21", 8'h21);
    checar("ret2_nivel", 32'(nivel), 0);
    limpa(); chamada = 1; alvo = 8'h70;
    for (int i = 1; i <= 4; i++) passo();
    checar("call4_nivel", 32'(nivel), 4);
    checar("call4_erro", 32'(erro), 0);
    passo();
    checar("overflow_erro", 32'(erro), 1);
    pc("overflow_pc", 8'h70);
    checar("overflow_nivel", 32'(nivel), 4);
    chamada = 0; retorno = 1; salto = 1; retomar = 1; alvo = 8'h11;
    passo(); passo();
    pc("sticky_pc", 8'h70);
    checar("sticky_nivel", 32'(nivel), 4);
    checar("sticky_erro", 32'(erro), 1);
    reset = 1; passo();
    pc("rst_err_pc", 8'h00);
    checar("rst_err_erro", 32'(erro), 0);
    checar("rst_err_nivel", 32'(nivel), 0);
    reset = 0; limpa(); retorno = 1; passo();
    checar("underflow_erro", 32'(erro), 1);
    pc("underflow_pc", 8'h00);
    reset = 1; limpa(); passo(); reset = 0;
    for (int i = 0; i < 5; i++) passo();
    pc("pre_halt", 8'h05);
    parar = 1; salto = 1; alvo = 8'h99; passo();
    pc("halt_pc", 8'h05);
    checar("halt_parado", 32'(parado), 1);
    parar = 0; passo();
    pc("halt_cmd_ignored", 8'h05);
    limpa(); retomar = 1; passo();
    checar("resume_parado", 32'(parado), 0);
    pc("resume_hold", 8'h05);
    limpa(); passo(); pc("resume_incr", 8'h06);
    parar = 1; passo(); checar("halt2_parado", 32'(parado), 1);
    retomar = 1; passo();
    checar("both_parado", 32'(parado), 0);
    pc("both_pc", 8'h06);
    limpa(); passo(); pc("after_both", 8'h07);
    salto = 1; chamada = 1; alvo = 8'h30; passo();
    pc("prio_pc", 8'h30);
    checar("prio_nivel", 32'(nivel), 0);
    limpa(); retorno = 1; passo();
    checar("prio_no_push", 32'(erro), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
